// File: rtl/pattern_gen.sv
// Configurable colour-bar test-pattern generator: vertical, horizontal, checkerboard and scrolling bars.
// Optional white one-pixel frame border when PATTERN_GEN_BORDER_EN is defined.
module pattern_gen #(
    parameter int HVID     = 640,
    parameter int VVID     = 480,
    parameter int NUM_BARS = 8
) (
    input  logic       clk_25,
    input  logic       n_rst,
    input  logic       load_enable,
    input  logic [9:0] horizontal_num,
    input  logic [9:0] vertical_num,
    input  logic       mode_valid,
    input  logic [1:0] mode_in,
    output logic       mode_ready,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam int BAR_W = HVID / NUM_BARS;
    localparam int BAR_H = VVID / NUM_BARS;
    localparam int BW    = $clog2(NUM_BARS);

    typedef enum logic {ST_IDLE, ST_PENDING} state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_mode, r_pend, w_mode;
    logic [BW-1:0]   r_scroll, w_scroll;
    logic [BW-1:0]   r_hbar, r_vbar, w_hbar, w_vbar, w_hbar_nxt, w_line_vbar, w_idx;
    logic [9:0]      r_hcnt, r_vcnt, w_hcnt, w_hcnt_nxt, w_line_vcnt;
    logic            w_hstart, w_fs, w_accept, w_apply;
    logic [23:0]     w_rgb, r_rgb;

    function automatic logic [23:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    palette = 24'hFF0000;
            3'd1:    palette = 24'h00FF00;
            3'd2:    palette = 24'h0000FF;
            3'd3:    palette = 24'hFFFFFF;
            3'd4:    palette = 24'hFFFF00;
            3'd5:    palette = 24'h00FFFF;
            3'd6:    palette = 24'hFF00FF;
            default: palette = 24'h000000;
        endcase
    endfunction

    // Handshake FSM
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = mode_valid;
                if (mode_valid) w_state_next = ST_PENDING;
            end
            ST_PENDING: begin
                w_apply = w_fs;
                if (w_fs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign mode_ready = (r_state == ST_IDLE);

    // Counter registers hold the position expected for the next pixel (horizontal)
    // and for the current line (vertical); h==0 reseeds both, so no divider is needed.
    always_comb begin
        w_hstart = load_enable && (horizontal_num == '0);
        w_fs     = w_hstart && (vertical_num == '0);

        w_hbar = w_hstart ? '0 : r_hbar;
        w_hcnt = w_hstart ? '0 : r_hcnt;
        if (w_hcnt == 10'(BAR_W - 1)) begin
            w_hcnt_nxt = '0;
            w_hbar_nxt = w_hbar + 1'b1;
        end else begin
            w_hcnt_nxt = w_hcnt + 10'd1;
            w_hbar_nxt = w_hbar;
        end

        if (vertical_num == '0) begin
            w_line_vcnt = '0;
            w_line_vbar = '0;
        end else if (r_vcnt == 10'(BAR_H - 1)) begin
            w_line_vcnt = '0;
            w_line_vbar = r_vbar + 1'b1;
        end else begin
            w_line_vcnt = r_vcnt + 10'd1;
            w_line_vbar = r_vbar;
        end
        w_vbar = w_hstart ? w_line_vbar : r_vbar;

        w_mode = w_apply ? r_pend : r_mode;
        if (w_apply)                          w_scroll = '0;
        else if (w_fs && (r_mode == 2'd3))    w_scroll = r_scroll + 1'b1;
        else                                  w_scroll = r_scroll;
    end

    always_comb begin
        w_idx = w_hbar;
        w_rgb = '0;
        case (w_mode)
            2'd0: begin w_idx = w_hbar;            w_rgb = palette(3'(w_idx)); end
            2'd1: begin w_idx = w_vbar;            w_rgb = palette(3'(w_idx)); end
            2'd2: w_rgb = (w_hbar[0] ^ w_vbar[0]) ? 24'hFFFFFF : 24'h000000;
            default: begin w_idx = w_hbar + w_scroll; w_rgb = palette(3'(w_idx)); end
        endcase
`ifdef PATTERN_GEN_BORDER_EN
        if (horizontal_num == '0 || horizontal_num == 10'(HVID - 1) ||
            vertical_num == '0 || vertical_num == 10'(VVID - 1))
            w_rgb = 24'hFFFFFF;
`endif
        if (!load_enable) w_rgb = '0;
    end

    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_mode   <= '0;
            r_pend   <= '0;
            r_scroll <= '0;
            r_hbar   <= '0;
            r_hcnt   <= '0;
            r_vbar   <= '0;
            r_vcnt   <= '0;
            r_rgb    <= '0;
        end else begin
            r_rgb    <= w_rgb;
            r_mode   <= w_mode;
            r_scroll <= w_scroll;
            if (w_accept) r_pend <= mode_in;
            if (load_enable) begin
                r_hbar <= w_hbar_nxt;
                r_hcnt <= w_hcnt_nxt;
            end
            if (w_hstart) begin
                r_vbar <= w_line_vbar;
                r_vcnt <= w_line_vcnt;
            end
        end
    end

    assign red   = r_rgb[23:16];
    assign green = r_rgb[15:8];
    assign blue  = r_rgb[7:0];

endmodule
